// File: rtl/chacha_pkg.sv
// Shared types, constants and index helpers for the ChaCha block sequencer.
// The quarter-round lane (a/b/c/d = 0..3) selects the state row; the column picks the word in it.
package chacha_pkg;

    localparam int WORD_W      = 32;
    localparam int STATE_WORDS = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADD  = 2'd2
    } fsm_state_e;

    localparam word_t CHACHA_C0 = 32'h6170_7865;
    localparam word_t CHACHA_C1 = 32'h3320_646e;
    localparam word_t CHACHA_C2 = 32'h7962_2d32;
    localparam word_t CHACHA_C3 = 32'h6b20_6574;

    // Column round: lane k of quarter-round g touches word 4*k + g.
    function automatic logic [3:0] col_idx(input logic [1:0] g, input logic [1:0] lane);
        return {lane, g};
    endfunction

    // Diagonal round: lane k shifts its column by k (mod 4).
    function automatic logic [3:0] diag_idx(input logic [1:0] g, input logic [1:0] lane);
        logic [1:0] col;
        col = g + lane;
        return {lane, col};
    endfunction

endpackage

// File: rtl/chacha_block_sequencer_qr.sv
// Combinational ChaCha quarter-round: four add/xor/rotate stages on a, b, c, d.
module chacha_block_sequencer_qr
    import chacha_pkg::*;
(
    input  word_t a_in,
    input  word_t b_in,
    input  word_t c_in,
    input  word_t d_in,
    output word_t a_out,
    output word_t b_out,
    output word_t c_out,
    output word_t d_out
);

    word_t a1, b1, c1, d1, a2, b2, c2, d2;

    always_comb begin
        a1 = a_in + b_in;
        d1 = d_in ^ a1;
        d1 = {d1[15:0], d1[31:16]};
        c1 = c_in + d1;
        b1 = b_in ^ c1;
        b1 = {b1[19:0], b1[31:20]};
        a2 = a1 + b1;
        d2 = d1 ^ a2;
        d2 = {d2[23:0], d2[31:24]};
        c2 = c1 + d2;
        b2 = b1 ^ c2;
        b2 = {b2[24:0], b2[31:25]};
    end

    assign a_out = a2;
    assign b_out = b2;
    assign c_out = c2;
    assign d_out = d2;

endmodule

// File: rtl/chacha_block_sequencer.sv
// ChaCha block function: one shared quarter-round per cycle over a 16-word state,
// with an optional final feed-forward add of the state captured at start.
module chacha_block_sequencer
    import chacha_pkg::*;
#(
    parameter int DOUBLE_ROUNDS = 10,
    parameter int FEEDFORWARD   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [3:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        start,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done
);

    localparam int STEPS = 8 * DOUBLE_ROUNDS;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    word_t st_q   [STATE_WORDS];
    word_t init_q [STATE_WORDS];

    logic       ld_we, start_acc, qr_we, add_en, last_step;
    logic [1:0] g;
    logic       diag;
    logic [3:0] idx    [4];
    word_t      qr_in  [4];
    word_t      qr_out [4];

    // Host handshake: ld_valid and start are single-cycle requests, honoured only in IDLE;
    // a load and a start in the same cycle performs the load and drops the start.
    assign ld_we     = (state_q == IDLE) && ld_valid;
    assign start_acc = (state_q == IDLE) && start && !ld_valid;
    assign qr_we     = (state_q == RUN);
    assign add_en    = (state_q == ADD);
    assign last_step = (cnt_q == LAST);

    // Bit 2 of the step count is the round parity: even rounds are columns, odd are diagonals.
    always_comb begin
        g    = cnt_q[1:0];
        diag = cnt_q[2];
        for (int l = 0; l < 4; l++) begin
            idx[l]   = diag ? diag_idx(g, 2'(l)) : col_idx(g, 2'(l));
            qr_in[l] = st_q[idx[l]];
        end
    end

    chacha_block_sequencer_qr u_qr (
        .a_in  (qr_in[0]),
        .b_in  (qr_in[1]),
        .c_in  (qr_in[2]),
        .d_in  (qr_in[3]),
        .a_out (qr_out[0]),
        .b_out (qr_out[1]),
        .c_out (qr_out[2]),
        .d_out (qr_out[3])
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (last_step) begin
                    if (FEEDFORWARD != 0) begin
                        state_d = ADD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ADD: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Per-word write decode; the three write sources are mutually exclusive by FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STATE_WORDS; i++) begin
                st_q[i]   <= '0;
                init_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STATE_WORDS; i++) begin
                if (ld_we && (ld_addr == 4'(i))) begin
                    st_q[i] <= ld_data;
                end else if (qr_we) begin
                    for (int l = 0; l < 4; l++) begin
                        if (idx[l] == 4'(i)) st_q[i] <= qr_out[l];
                    end
                end else if (add_en) begin
                    st_q[i] <= st_q[i] + init_q[i];
                end
                if (start_acc) init_q[i] <= st_q[i];
            end
        end
    end

    assign rd_data = st_q[rd_addr];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Directed bench for chacha_block_sequencer: runs feed-forward and raw variants side by side
// against RFC 7539 vectors and an independent ChaCha reference model.
module tb_chacha_block_sequencer;
    import chacha_pkg::*;

    typedef logic [15:0][31:0] blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        start = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_ff, rd_nf;
    logic        busy_ff, busy_nf, done_ff, done_nf;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_nf_q[$];

    blk_t vec, rnd, zero_blk;

    chacha_block_sequencer #(.DOUBLE_ROUNDS(10), .FEEDFORWARD(1)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_ff), .busy(busy_ff), .done(done_ff)
    );

    chacha_block_sequencer #(.DOUBLE_ROUNDS(10), .FEEDFORWARD(0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_nf), .busy(busy_nf), .done(done_nf)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model
    function automatic logic [31:0] rotl(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic blk_t qrm(blk_t x, int a, int b, int c, int d);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
        return x;
    endfunction

    function automatic blk_t chacha_ref(blk_t in, bit ff);
        blk_t x = in;
        for (int r = 0; r < 10; r++) begin
            x = qrm(x, 0, 4, 8, 12);  x = qrm(x, 1, 5, 9, 13);
            x = qrm(x, 2, 6, 10, 14); x = qrm(x, 3, 7, 11, 15);
            x = qrm(x, 0, 5, 10, 15); x = qrm(x, 1, 6, 11, 12);
            x = qrm(x, 2, 7, 8, 13);  x = qrm(x, 3, 4, 9, 14);
        end
        if (ff) for (int i = 0; i < 16; i++) x[i] = x[i] + in[i];
        return x;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic load_blk(blk_t b);
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 4'(i);
            ld_data  = b[i];
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic push_expected(blk_t in);
        blk_t e_ff, e_nf;
        e_ff = chacha_ref(in, 1'b1);
        e_nf = chacha_ref(in, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(e_ff[i]);
            exp_nf_q.push_back(e_nf[i]);
        end
    endtask

    task automatic push_zeros();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('0);
            exp_nf_q.push_back('0);
        end
    endtask

    // Scoreboard: pop expected words and compare against read-back of both variants.
    task automatic read_all(string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            if (exp_q.size() == 0 || exp_nf_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd16);
            end else begin
                check($sformatf("%s_ff_w%0d", tag, i), rd_ff, exp_q.pop_front());
                check($sformatf("%s_nf_w%0d", tag, i), rd_nf, exp_nf_q.pop_front());
            end
        end
    endtask

    // Start a block, watch 90 cycles, check done/busy timing for both variants.
    task automatic run_block(string tag, bit inject);
        int first_ff = -1, first_nf = -1;
        int cnt_done_ff = 0, cnt_done_nf = 0, cnt_busy_ff = 0, cnt_busy_nf = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 90; n++) begin
            if (busy_ff) cnt_busy_ff++;
            if (busy_nf) cnt_busy_nf++;
            if (done_ff) begin cnt_done_ff++; if (first_ff < 0) first_ff = n; end
            if (done_nf) begin cnt_done_nf++; if (first_nf < 0) first_nf = n; end
            if (inject && n == 10) begin
                ld_valid = 1'b1; ld_addr = 4'd0; ld_data = 32'hdead_beef; start = 1'b1;
            end
            if (inject && n == 11) begin
                ld_valid = 1'b0; start = 1'b0;
            end
            tick();
        end
        check({tag, "_done_cyc_ff"}, 32'(first_ff), 32'd81);
        check({tag, "_done_cyc_nf"}, 32'(first_nf), 32'd80);
        check({tag, "_done_len_ff"}, 32'(cnt_done_ff), 32'd1);
        check({tag, "_done_len_nf"}, 32'(cnt_done_nf), 32'd1);
        check({tag, "_busy_len_ff"}, 32'(cnt_busy_ff), 32'd81);
        check({tag, "_busy_len_nf"}, 32'(cnt_busy_nf), 32'd80);
    endtask

    task automatic check_rfc(string tag);
        rd_addr = 4'd0;  #1;
        check({tag, "_w0_ff"}, rd_ff, 32'he4e7_f110);
        check({tag, "_w0_nf"}, rd_nf, 32'h8377_78ab);
        rd_addr = 4'd15; #1;
        check({tag, "_w15_ff"}, rd_ff, 32'h4e3c_50a2);
        check({tag, "_w15_nf"}, rd_nf, 32'h4e3c_50a2);
    endtask

    initial begin
        zero_blk = '0;
        vec[0] = CHACHA_C0; vec[1] = CHACHA_C1; vec[2] = CHACHA_C2; vec[3] = CHACHA_C3;
        for (int k = 0; k < 8; k++)
            vec[4 + k] = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
        vec[12] = 32'h0000_0001;
        vec[13] = 32'h0900_0000;
        vec[14] = 32'h4a00_0000;
        vec[15] = 32'h0000_0000;

        // 1. Reset
        rst_n = 1'b0;
        tick(); tick();
        check("rst_busy_ff", 32'(busy_ff), 32'd0);
        check("rst_done_ff", 32'(done_ff), 32'd0);
        check("rst_busy_nf", 32'(busy_nf), 32'd0);
        check("rst_done_nf", 32'(done_nf), 32'd0);
        push_zeros();
        read_all("rst");
        rst_n = 1'b1;
        tick();

        // 2. Zero state
        load_blk(zero_blk);
        push_zeros();
        run_block("zero", 1'b0);
        read_all("zero");

        // 3/4. RFC 7539 2.3.2, with a load and start attempted mid-run
        load_blk(vec);
        push_expected(vec);
        run_block("rfc", 1'b1);
        check_rfc("rfc");
        read_all("rfc");

        // 5. Load and start in the same idle cycle: load wins, no run
        ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 32'h1234_5678; start = 1'b1;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("ldstart_busy_ff", 32'(busy_ff), 32'd0);
            check("ldstart_busy_nf", 32'(busy_nf), 32'd0);
            tick();
        end
        rd_addr = 4'd3; #1;
        check("ldstart_w3_ff", rd_ff, 32'h1234_5678);
        check("ldstart_w3_nf", rd_nf, 32'h1234_5678);

        // Random state against the reference model
        for (int i = 0; i < 16; i++) rnd[i] = $urandom_range(32'hffff_ffff, 0);
        load_blk(rnd);
        push_expected(rnd);
        run_block("rand", 1'b0);
        read_all("rand");

        // 6. Reset in the middle of a run (step 37)
        load_blk(vec);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (37) tick();
        check("midrst_busy_before", 32'(busy_ff), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_busy_ff", 32'(busy_ff), 32'd0);
        check("midrst_busy_nf", 32'(busy_nf), 32'd0);
        check("midrst_done_ff", 32'(done_ff), 32'd0);
        check("midrst_done_nf", 32'(done_nf), 32'd0);
        push_zeros();
        read_all("midrst");
        rst_n = 1'b1;
        begin
            int dones = 0;
            for (int n = 0; n < 90; n++) begin
                if (done_ff || done_nf || busy_ff || busy_nf) dones++;
                tick();
            end
            check("midrst_quiet", 32'(dones), 32'd0);
        end
        load_blk(vec);
        push_expected(vec);
        run_block("rerun", 1'b0);
        check_rfc("rerun");
        read_all("rerun");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
